// File: rtl/decode_stage.sv
// RV32I decode stage: register file, immediate/ALU-control decode, load-use interlock and a one-entry skid buffer.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data into the captured operands.
module decode_stage #(
    parameter int XLEN       = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH+31:0]  i_if_pkt_data,
    input  logic                    i_if_valid,
    output logic                    o_if_ready,
    input  logic                    i_flush,
    input  logic                    i_wr,
    input  logic [4:0]              i_rd,
    input  logic [XLEN-1:0]         i_write_data,
    input  logic                    i_ex_load_valid,
    input  logic [4:0]              i_ex_load_rd,
    output logic                    o_ex_valid,
    input  logic                    i_ex_ready,
    output logic [XLEN-1:0]         o_rs1_data,
    output logic [XLEN-1:0]         o_rs2_data,
    output logic [XLEN-1:0]         o_imm_data,
    output logic [4:0]              o_rd,
    output logic [6:0]              o_opcode,
    output logic [2:0]              o_func3,
    output logic [3:0]              o_alu_ctrl,
    output logic [ADDR_WIDTH-1:0]   o_pc
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [4:0]            rd;
        logic [6:0]            opcode;
        logic [2:0]            func3;
        logic [3:0]            alu_ctrl;
        logic [ADDR_WIDTH-1:0] pc;
    } dec_t;

    function automatic logic signed [XLEN-1:0] imm_gen(input logic [31:0] ins);
        logic signed [31:0] imm32;
        imm32 = '0;
        case (ins[6:0])
            OPC_OPIMM, OPC_LOAD, OPC_JALR: imm32 = {{20{ins[31]}}, ins[31:20]};
            OPC_STORE:                     imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            OPC_BRANCH:                    imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            OPC_LUI, OPC_AUIPC:            imm32 = {ins[31:12], 12'b0};
            OPC_JAL:                       imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            default:                       imm32 = '0;
        endcase
        return XLEN'(imm32);
    endfunction

    function automatic logic [3:0] alu_gen(input logic [31:0] ins);
        case (ins[6:0])
            OPC_OP:    alu_gen = {ins[30], ins[14:12]};
            OPC_OPIMM: alu_gen = {(ins[14:12] == 3'b101) ? ins[30] : 1'b0, ins[14:12]};
            default:   alu_gen = 4'b0000;
        endcase
    endfunction

    // Bit 0: rs1 is read, bit 1: rs2 is read. Unknown opcodes are treated as reading both.
    function automatic logic [1:0] rs_use(input logic [6:0] opc);
        case (opc)
            OPC_LUI, OPC_AUIPC, OPC_JAL:   rs_use = 2'b00;
            OPC_OPIMM, OPC_LOAD, OPC_JALR: rs_use = 2'b01;
            default:                       rs_use = 2'b11;
        endcase
    endfunction

    logic [XLEN-1:0]       rf [32];
    logic [31:0]           instr_p0;
    logic [ADDR_WIDTH-1:0] pc_p0;
    logic [4:0]            rs1_p0;
    logic [4:0]            rs2_p0;
    logic [1:0]            use_p0;
    logic                  hazard_p0;
    logic                  xfer_p0;
    dec_t                  dec_p0;
    dec_t                  skid_p1;
    logic                  skid_vld_p1;
    dec_t                  out_p2;
    logic                  vld_p2;

    assign instr_p0 = i_if_pkt_data[31:0];
    assign pc_p0    = i_if_pkt_data[ADDR_WIDTH+31:32];
    assign rs1_p0   = instr_p0[19:15];
    assign rs2_p0   = instr_p0[24:20];
    assign use_p0   = rs_use(instr_p0[6:0]);

    assign hazard_p0 = i_ex_load_valid && (i_ex_load_rd != 5'd0) &&
                       ((use_p0[0] && (i_ex_load_rd == rs1_p0)) ||
                        (use_p0[1] && (i_ex_load_rd == rs2_p0)));

    assign o_if_ready = ~skid_vld_p1 & ~hazard_p0;
    assign xfer_p0    = i_if_valid & o_if_ready;

    // Register file; x0 is never written so it always reads zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) rf[i] <= '0;
        end else if (i_wr && (i_rd != 5'd0)) begin
            rf[i_rd] <= i_write_data;
        end
    end

    always_comb begin
        dec_p0.rs1_data = (rs1_p0 == 5'd0) ? '0 : rf[rs1_p0];
        dec_p0.rs2_data = (rs2_p0 == 5'd0) ? '0 : rf[rs2_p0];
`ifdef DECODE_WB_BYPASS_EN
        if (i_wr && (i_rd != 5'd0) && (i_rd == rs1_p0)) dec_p0.rs1_data = i_write_data;
        if (i_wr && (i_rd != 5'd0) && (i_rd == rs2_p0)) dec_p0.rs2_data = i_write_data;
`endif
        dec_p0.imm      = imm_gen(instr_p0);
        dec_p0.rd       = instr_p0[11:7];
        dec_p0.opcode   = instr_p0[6:0];
        dec_p0.func3    = instr_p0[14:12];
        dec_p0.alu_ctrl = alu_gen(instr_p0);
        dec_p0.pc       = pc_p0;
    end

    // p0 -> p1/p2: skid entry always drains before any new transfer is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p2      <= 1'b0;
            skid_vld_p1 <= 1'b0;
            out_p2      <= '0;
            skid_p1     <= '0;
        end else if (i_flush) begin
            vld_p2      <= 1'b0;
            skid_vld_p1 <= 1'b0;
        end else if (skid_vld_p1) begin
            if (i_ex_ready) begin
                out_p2      <= skid_p1;
                skid_vld_p1 <= 1'b0;
            end
        end else if (xfer_p0) begin
            if (!vld_p2 || i_ex_ready) begin
                out_p2 <= dec_p0;
                vld_p2 <= 1'b1;
            end else begin
                skid_p1     <= dec_p0;
                skid_vld_p1 <= 1'b1;
            end
        end else if (i_ex_ready) begin
            vld_p2 <= 1'b0;
        end
    end

    assign o_ex_valid = vld_p2;
    assign o_rs1_data = out_p2.rs1_data;
    assign o_rs2_data = out_p2.rs2_data;
    assign o_imm_data = out_p2.imm;
    assign o_rd       = out_p2.rd;
    assign o_opcode   = out_p2.opcode;
    assign o_func3    = out_p2.func3;
    assign o_alu_ctrl = out_p2.alu_ctrl;
    assign o_pc       = out_p2.pc;

endmodule
